// File: rtl/adc_capture_dumper.sv
// adc_capture_dumper
// Captures DEPTH sample vectors on an 's'/'S' command, then streams them out
// over a valid/ready byte interface as uppercase ASCII hex, one line per
// sample index, channels separated by commas, lines ended by LF then CR.
// An 'x'/'X' command aborts a capture or dump (an in-flight byte completes).
module adc_capture_dumper #(
  parameter int SAMPLE_BITS  = 24,
  parameter int NUM_CHANNELS = 1,
  parameter int DEPTH        = 1024,
  parameter int BYTE_GAP     = 5000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0] in_data,
  input  logic                                in_valid,
  input  logic                                rvalid,
  output logic                                rready,
  input  logic [7:0]                          rdata,
  output logic                                tvalid,
  input  logic                                tready,
  output logic [7:0]                          tdata,
  output logic                                busy,
  output logic                                done
);

  localparam int NIB  = (SAMPLE_BITS + 3) / 4;
  localparam int PADW = NIB * 4;
  localparam int WW   = NUM_CHANNELS * SAMPLE_BITS;
  localparam int AW   = $clog2(DEPTH);
  localparam int GW   = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam int CHW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int NBW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);
  localparam logic [GW-1:0]  GAP_MAX  = GW'(BYTE_GAP);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CHANNELS - 1);
  localparam logic [NBW-1:0] LAST_NIB = NBW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DUMP    = 2'd2
  } state_t;

  // What kind of character the next tx byte of the current line is
  typedef enum logic [1:0] {
    K_HEX   = 2'd0,
    K_COMMA = 2'd1,
    K_LF    = 2'd2,
    K_CR    = 2'd3
  } kind_t;

  // Nibble to uppercase ASCII hex digit
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, n};
    end else begin
      hex_ascii = 8'h37 + {4'h0, n};
    end
  endfunction

  state_t           state_r, state_nx_s;
  kind_t            kind_r;
  logic [AW-1:0]    wr_idx_r, rd_idx_r;
  logic [CHW-1:0]   ch_r;
  logic [NBW-1:0]   nib_r;
  logic [GW-1:0]    gap_r;
  logic [WW-1:0]    mem_r [DEPTH];
  logic [WW-1:0]    mem_q_r, word_r;
  logic             have_word_r, ld_r, abort_r;
  logic             tvalid_r, rready_r, busy_r, done_r;
  logic [7:0]       tdata_r;

  logic             rx_fire_s, is_s_s, is_x_s, hs_s, last_byte_s, rise_s, done_nx_s;
  logic [SAMPLE_BITS-1:0] chan_s;
  logic [PADW-1:0]  pad_s;
  logic [3:0]       nib_val_s;
  logic [7:0]       byte_s;

  assign rready = rready_r;
  assign tvalid = tvalid_r;
  assign tdata  = tdata_r;
  assign busy   = busy_r;
  assign done   = done_r;

  // Decode rx commands, tx handshake and the tx-rise condition
  always_comb begin
    rx_fire_s   = rvalid & rready_r;
    is_s_s      = rx_fire_s & ((rdata == 8'h73) | (rdata == 8'h53));
    is_x_s      = rx_fire_s & ((rdata == 8'h78) | (rdata == 8'h58));
    hs_s        = tvalid_r & tready;
    last_byte_s = (kind_r == K_CR) & (rd_idx_r == LAST_IDX);
    rise_s      = (state_r == S_DUMP) & ~tvalid_r & have_word_r & (gap_r == GAP_MAX);
  end

  // Next-state logic; a final CR handshake wins over a same-cycle abort
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (is_s_s) begin
          state_nx_s = S_CAPTURE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (is_x_s) begin
          state_nx_s = S_IDLE;
        end else if (in_valid && (wr_idx_r == LAST_IDX)) begin
          state_nx_s = S_DUMP;
        end else begin
          state_nx_s = S_CAPTURE;
        end
      end
      S_DUMP: begin
        if (hs_s && last_byte_s) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
        end else if (hs_s && (abort_r || is_x_s)) begin
          state_nx_s = S_IDLE;
        end else if (is_x_s && !tvalid_r) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DUMP;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Select the character for the current line position (top nibble zero-padded)
  always_comb begin
    chan_s    = SAMPLE_BITS'(word_r >> (int'(ch_r) * SAMPLE_BITS));
    pad_s     = PADW'(chan_s);
    nib_val_s = 4'(pad_s >> ((NIB - 1 - int'(nib_r)) * 4));
    case (kind_r)
      K_HEX:   byte_s = hex_ascii(nib_val_s);
      K_COMMA: byte_s = 8'h2C;
      K_LF:    byte_s = 8'h0A;
      K_CR:    byte_s = 8'h0D;
      default: byte_s = 8'h00;
    endcase
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rready_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      busy_r   <= (state_nx_s != S_IDLE);
      done_r   <= done_nx_s;
      rready_r <= 1'b1;
    end
  end

  // Sample RAM: capture writes, one-cycle-latency read at rd_idx (contents not reset)
  always_ff @(posedge clk) begin
    if ((state_r == S_CAPTURE) && in_valid) begin
      mem_r[wr_idx_r] <= in_data;
    end
    mem_q_r <= mem_r[rd_idx_r];
  end

  // Indices, word latch, line sequencing, gap counter and tx byte register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_r    <= '0;
      rd_idx_r    <= '0;
      ch_r        <= '0;
      nib_r       <= '0;
      kind_r      <= K_HEX;
      gap_r       <= '0;
      word_r      <= '0;
      have_word_r <= 1'b0;
      ld_r        <= 1'b0;
      abort_r     <= 1'b0;
      tvalid_r    <= 1'b0;
      tdata_r     <= 8'h00;
    end else begin
      if ((state_r == S_IDLE) && (state_nx_s == S_CAPTURE)) begin
        wr_idx_r <= '0;
      end else if ((state_r == S_CAPTURE) && in_valid && (wr_idx_r != LAST_IDX)) begin
        wr_idx_r <= wr_idx_r + AW'(1);
      end

      if ((state_r == S_CAPTURE) && (state_nx_s == S_DUMP)) begin
        rd_idx_r    <= '0;
        ch_r        <= '0;
        nib_r       <= '0;
        kind_r      <= K_HEX;
        gap_r       <= '0;
        have_word_r <= 1'b0;
        ld_r        <= 1'b0;
        abort_r     <= 1'b0;
      end else if (state_r == S_DUMP) begin
        // First cycle lets the RAM output settle on rd_idx, second latches it
        if (!have_word_r) begin
          if (ld_r) begin
            word_r      <= mem_q_r;
            have_word_r <= 1'b1;
            ld_r        <= 1'b0;
          end else begin
            ld_r <= 1'b1;
          end
        end

        if (hs_s) begin
          gap_r <= '0;
        end else if (!tvalid_r && (gap_r != GAP_MAX)) begin
          gap_r <= gap_r + GW'(1);
        end

        if (is_x_s && tvalid_r && !hs_s) begin
          abort_r <= 1'b1;
        end

        if (hs_s) begin
          case (kind_r)
            K_HEX: begin
              if (nib_r == LAST_NIB) begin
                nib_r  <= '0;
                kind_r <= (ch_r == LAST_CH) ? K_LF : K_COMMA;
              end else begin
                nib_r <= nib_r + NBW'(1);
              end
            end
            K_COMMA: begin
              ch_r   <= ch_r + CHW'(1);
              kind_r <= K_HEX;
            end
            K_LF: begin
              kind_r <= K_CR;
            end
            K_CR: begin
              ch_r   <= '0;
              nib_r  <= '0;
              kind_r <= K_HEX;
              if (rd_idx_r != LAST_IDX) begin
                rd_idx_r    <= rd_idx_r + AW'(1);
                have_word_r <= 1'b0;
                ld_r        <= 1'b0;
              end
            end
            default: begin
              kind_r <= K_HEX;
            end
          endcase
        end
      end

      if (state_nx_s != S_DUMP) begin
        tvalid_r <= 1'b0;
      end else if (hs_s) begin
        tvalid_r <= 1'b0;
      end else if (rise_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= byte_s;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_dumper.sv
// Self-checking bench for adc_capture_dumper: main instance with 2x12-bit
// channels, DEPTH 4, BYTE_GAP 3, plus two single-channel instances (10-bit and
// 24-bit, BYTE_GAP 0) for padding and back-to-back pacing.
module tb_adc_capture_dumper;

  localparam int SB  = 12;
  localparam int NC  = 2;
  localparam int DP  = 4;
  localparam int GAP = 3;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   in_data = '0;
  logic          in_valid = 1'b0, rvalid = 1'b0, tready = 1'b1;
  logic [7:0]    rdata = 8'h00;
  logic          rready, tvalid, busy, done;
  logic [7:0]    tdata;

  logic          rvalid2 = 1'b0, in_valid2 = 1'b0, tready2 = 1'b1;
  logic [9:0]    in_data_b = '0;
  logic [23:0]   in_data_c = '0;
  logic          rready_b, tvalid_b, busy_b, done_b;
  logic          rready_c, tvalid_c, busy_c, done_c;
  logic [7:0]    tdata_b, tdata_c;

  int            tests = 0, fails = 0;
  bq_t           rx_a, rx_b, rx_c, exp_q;
  logic [31:0]   smp [$];
  int            stab_err = 0, gap_err = 0, done_cnt = 0, bb_err = 0;
  logic          pv = 1'b0, phs = 1'b0, hsp = 1'b0, phs_b = 1'b0;
  logic [7:0]    ptd = 8'h00;
  int            low_cnt = 0;
  int            mode = 0, stall_left = 0;
  bit            junk_en = 1'b0;
  string         hexs = "0123456789ABCDEF";

  always #5 clk = ~clk;

  adc_capture_dumper #(.SAMPLE_BITS(SB), .NUM_CHANNELS(NC), .DEPTH(DP), .BYTE_GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .busy(busy), .done(done));

  adc_capture_dumper #(.SAMPLE_BITS(10), .NUM_CHANNELS(1), .DEPTH(2), .BYTE_GAP(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid2),
    .rvalid(rvalid2), .rready(rready_b), .rdata(rdata),
    .tvalid(tvalid_b), .tready(tready2), .tdata(tdata_b), .busy(busy_b), .done(done_b));

  adc_capture_dumper #(.SAMPLE_BITS(24), .NUM_CHANNELS(1), .DEPTH(2), .BYTE_GAP(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_valid(in_valid2),
    .rvalid(rvalid2), .rready(rready_c), .rdata(rdata),
    .tvalid(tvalid_c), .tready(tready2), .tdata(tdata_c), .busy(busy_c), .done(done_c));

  // Main tx monitor: collect bytes, check stability under stall, gap after handshake, count done
  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0; phs <= 1'b0; hsp <= 1'b0; low_cnt <= 0;
    end else begin
      if (pv && !phs && (!tvalid || (tdata !== ptd))) stab_err <= stab_err + 1;
      if (tvalid && hsp && (low_cnt < GAP)) gap_err <= gap_err + 1;
      if (tvalid && tready) begin
        hsp <= 1'b1; low_cnt <= 0;
        rx_a.push_back(tdata);
      end else if (tvalid) begin
        hsp <= 1'b0;
      end else begin
        low_cnt <= low_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      pv <= tvalid; ptd <= tdata; phs <= tvalid && tready;
    end
  end

  // Secondary monitors: collect bytes, flag handshakes on adjacent cycles
  always @(posedge clk) begin
    if (rst_n) begin
      if (tvalid_b && tready2) rx_b.push_back(tdata_b);
      if (tvalid_c && tready2) rx_c.push_back(tdata_c);
      if (tvalid_b && tready2 && phs_b) bb_err <= bb_err + 1;
      phs_b <= tvalid_b && tready2;
    end else begin
      phs_b <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: step to the falling edge and refresh tready/junk stimulus
  task automatic tick();
    @(negedge clk);
    case (mode)
      0: tready = 1'b1;
      1: begin
        if (stall_left > 0) begin
          tready = 1'b0; stall_left--;
        end else begin
          tready = 1'b1;
          if ($urandom_range(0, 2) == 0) stall_left = $urandom_range(0, 20);
        end
      end
      2: tready = 1'b0;
      default: tready = 1'b1;
    endcase
    if (junk_en) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 24'($urandom);
    end
  endtask

  task automatic send_main(input logic [7:0] c);
    rdata = c; rvalid = 1'b1; tick(); rvalid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] c);
    rdata = c; rvalid2 = 1'b1; tick(); rvalid2 = 1'b0;
  endtask

  task automatic capture_one(input int i);
    in_data = {12'(smp[i*NC+1]), 12'(smp[i*NC])}; in_valid = 1'b1; tick(); in_valid = 1'b0;
  endtask

  task automatic capture_all();
    for (int i = 0; i < DP; i++) capture_one(i);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0) && (n < budget)) begin tick(); n++; end
    check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_tvalid(input string tag, input int budget);
    int n = 0;
    while ((tvalid !== 1'b1) && (n < budget)) begin tick(); n++; end
    check({tag, "_tvalid_timeout"}, 64'(tvalid), 64'd1);
  endtask

  function automatic void load_exp_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endfunction

  function automatic void rand_samples();
    smp.delete();
    for (int i = 0; i < DP * NC; i++) smp.push_back(32'($urandom_range(0, 4095)));
  endfunction

  // Reference: text lines built from the sample table
  function automatic void model();
    int nib;
    nib = (SB + 3) / 4;
    exp_q.delete();
    for (int l = 0; l < DP; l++) begin
      for (int c = 0; c < NC; c++) begin
        for (int k = nib - 1; k >= 0; k--) exp_q.push_back(8'(hexs[(smp[l*NC+c] >> (4*k)) & 32'hF]));
        if (c < NC - 1) exp_q.push_back(8'h2C);
      end
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0D);
    end
  endfunction

  task automatic check_stream(input string tag, input bq_t got, input int off);
    int n, d;
    logic [7:0] ob, eb;
    n = got.size() - off;
    d = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++) if ((d < 0) && (got[off+i] !== exp_q[i])) d = i;
    if ((d < 0) && (n != exp_q.size())) d = (n < exp_q.size()) ? n : exp_q.size();
    ob = (d >= 0 && d < n) ? got[off+d] : 8'h00;
    eb = (d >= 0 && d < exp_q.size()) ? exp_q[d] : 8'h00;
    tests++;
    assert (d == -1) else begin
      fails++;
      $error("FAIL %s: stream differs at byte %0d observed %0h expected %0h (got %0d bytes, want %0d)",
             tag, d, ob, eb, n, exp_q.size());
    end
  endtask

  initial begin
    int off, d0, n0, cnt;
    #2;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    tick(); tick(); rst_n = 1'b1; tick();
    check("rready_after_rst", 64'(rready), 64'd1);

    // Directed two-channel dump
    smp = '{32'h123, 32'h0AB, 32'h000, 32'hFFF, 32'hC0D, 32'h010, 32'h7FF, 32'h800};
    off = rx_a.size(); d0 = done_cnt;
    send_main(8'h73);
    check("busy_capture", 64'(busy), 64'd1);
    capture_all();
    check("busy_dump", 64'(busy), 64'd1);
    wait_idle("t1", 3000);
    check("t1_done_at_idle", 64'(done), 64'd1);
    tick();
    check("t1_done_one_cycle", 64'(done), 64'd0);
    tick();
    load_exp_str("123,0AB\n\r000,FFF\n\rC0D,010\n\r7FF,800\n\r");
    check_stream("t1_stream", rx_a, off);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);

    // Padding and zero-gap pacing on the single-channel instances
    send2(8'h53);
    in_data_b = 10'h3FF; in_data_c = 24'hA5F00D; in_valid2 = 1'b1; tick();
    in_data_b = 10'h001; in_data_c = 24'h00000F; tick(); in_valid2 = 1'b0;
    cnt = 0;
    while (((busy_b !== 1'b0) || (busy_c !== 1'b0)) && (cnt < 400)) begin tick(); cnt++; end
    check("t2_idle_timeout", 64'({busy_b, busy_c}), 64'd0);
    load_exp_str("3FF\n\r001\n\r");
    check_stream("t2_10bit", rx_b, 0);
    load_exp_str("A5F00D\n\r00000F\n\r");
    check_stream("t2_24bit", rx_c, 0);
    check("t2_back_to_back", 64'(bb_err), 64'd0);

    // Random data, random tready stalls, stray in_valid while idle and dumping
    for (int it = 0; it < 3; it++) begin
      junk_en = 1'b1; repeat (8) tick(); junk_en = 1'b0; in_valid = 1'b0;
      rand_samples(); model(); off = rx_a.size();
      send_main((it % 2 == 0) ? 8'h73 : 8'h53);
      capture_all();
      mode = 1; junk_en = 1'b1;
      wait_idle("t3", 6000);
      junk_en = 1'b0; in_valid = 1'b0; mode = 0;
      tick(); tick();
      check_stream("t3_stream", rx_a, off);
    end
    check("t3_tdata_stable", 64'(stab_err), 64'd0);
    check("t3_gap", 64'(gap_err), 64'd0);

    // 's' during capture and dump is ignored
    rand_samples(); model(); off = rx_a.size();
    send_main(8'h73); capture_one(0); send_main(8'h73); capture_one(1);
    send_main(8'h53); capture_one(2); capture_one(3);
    repeat (20) tick();
    send_main(8'h73);
    wait_idle("t4s", 3000);
    tick(); tick();
    check_stream("t4_s_ignored", rx_a, off);

    // Abort while a byte is stalled: byte completes, then idle with no done
    rand_samples(); model();
    send_main(8'h73); capture_all();
    mode = 2;
    wait_tvalid("t4x", 200);
    n0 = rx_a.size(); d0 = done_cnt;
    send_main(8'h78);
    repeat (9) tick();
    check("t4x_held_tvalid", 64'(tvalid), 64'd1);
    check("t4x_held_busy", 64'(busy), 64'd1);
    check("t4x_held_count", 64'(rx_a.size()), 64'(n0));
    mode = 0; tick(); tick();
    check("t4x_busy_after", 64'(busy), 64'd0);
    check("t4x_count_after", 64'(rx_a.size()), 64'(n0 + 1));
    check("t4x_byte", 64'(rx_a[n0]), 64'(exp_q[0]));
    repeat (10) tick();
    check("t4x_no_more", 64'(rx_a.size()), 64'(n0 + 1));
    check("t4x_no_done", 64'(done_cnt), 64'(d0));

    // Abort during capture, and during dump before any byte
    send_main(8'h53); capture_one(0); send_main(8'h58);
    check("t4_abort_capture", 64'(busy), 64'd0);
    n0 = rx_a.size(); d0 = done_cnt;
    send_main(8'h73); capture_all(); send_main(8'h78);
    check("t4_abort_dump_idle", 64'(busy), 64'd0);
    repeat (10) tick();
    check("t4_abort_dump_bytes", 64'(rx_a.size()), 64'(n0));
    check("t4_abort_dump_done", 64'(done_cnt), 64'(d0));

    // Fresh capture after abort
    rand_samples(); model(); off = rx_a.size();
    send_main(8'h73); capture_all();
    wait_idle("t4f", 3000);
    tick(); tick();
    check_stream("t4_fresh", rx_a, off);

    // Reset in the middle of a dump with tvalid high
    rand_samples();
    send_main(8'h73); capture_all();
    wait_tvalid("t6", 200);
    rst_n = 1'b0;
    #1;
    check("t6_tvalid_low", 64'(tvalid), 64'd0);
    check("t6_busy_low", 64'(busy), 64'd0);
    tick(); rst_n = 1'b1; tick();
    check("t6_rready", 64'(rready), 64'd1);
    rand_samples(); model(); off = rx_a.size();
    send_main(8'h53); capture_all();
    wait_idle("t6", 3000);
    tick(); tick();
    check_stream("t6_stream", rx_a, off);

    check("final_tdata_stable", 64'(stab_err), 64'd0);
    check("final_gap", 64'(gap_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
